// File: rtl/axis_slave_fifo.sv
// Show-ahead AXI-stream slave FIFO with stall-protocol violation detection; optional beat counter under AXIS_SLAVE_FIFO_STATS_EN.
// Latency: one cycle from push edge to valid_out/data_out when empty; no empty-to-output bypass.
// Backpressure: ready_sys depends only on registered occupancy (never on ready_in); full FIFO stalls upstream.
module axis_slave_fifo #(
    parameter int DATA_WIDTH = 512,
    parameter int DEPTH      = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     valid,
    input  logic [DATA_WIDTH-1:0]    data_in,
    output logic                     ready_sys,
    output logic                     valid_out,
    output logic [DATA_WIDTH-1:0]    data_out,
    input  logic                     ready_in,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
`ifdef AXIS_SLAVE_FIFO_STATS_EN
    ,
    output logic [31:0]              beat_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = DEPTH[AW:0];
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW-1:0] PTR_ONE  = 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  push;
    logic                  pop;
    logic                  stall;
    logic                  stall_prev;
    logic [DATA_WIDTH-1:0] stall_dat;

    assign ready_sys = (count != FULL_CNT);
    assign valid_out = (count != '0);
    assign data_out  = mem[rd_ptr];
    assign push      = valid && ready_sys;
    assign pop       = valid_out && ready_in;
    assign stall     = valid && !ready_sys;

    // Storage carries no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // A violation is data_in changing between two back-to-back stall cycles.
    always_ff @(posedge clk) begin
        if (stall) begin
            stall_dat <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_prev <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            stall_prev <= stall;
            if (stall && stall_prev && (data_in != stall_dat)) begin
                overflow <= 1'b1;
            end
        end
    end

`ifdef AXIS_SLAVE_FIFO_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            beat_cnt <= '0;
        end else if (pop) begin
            beat_cnt <= beat_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_axis_slave_fifo.sv
// Bench for axis_slave_fifo: directed scenarios then randomized traffic against a queue-based reference model.
module tb_axis_slave_fifo;

    localparam int DW    = 512;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          valid;
    logic [DW-1:0] data_in;
    logic          ready_sys;
    logic          valid_out;
    logic [DW-1:0] data_out;
    logic          ready_in;
    logic [CW-1:0] count;
    logic          overflow;
`ifdef AXIS_SLAVE_FIFO_STATS_EN
    logic [31:0]   beat_cnt;
`endif

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic [DW-1:0] q [$];
    bit            m_ovf;
    bit            m_stall_prev;
    logic [DW-1:0] m_stall_dat;
    logic [31:0]   m_beats;

    always #5 clk = ~clk;

    axis_slave_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .valid     (valid),
        .data_in   (data_in),
        .ready_sys (ready_sys),
        .valid_out (valid_out),
        .data_out  (data_out),
        .ready_in  (ready_in),
        .count     (count),
        .overflow  (overflow)
`ifdef AXIS_SLAVE_FIFO_STATS_EN
        ,
        .beat_cnt  (beat_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: model consumes the inputs held across the edge, then outputs are compared.
    task automatic step();
        bit do_push, do_pop, stall;
        do_push = valid && (q.size() < DEPTH);
        do_pop  = ready_in && (q.size() > 0);
        stall   = valid && (q.size() == DEPTH);
        @(posedge clk);
        if (reset) begin
            q.delete();
            m_ovf        = 1'b0;
            m_stall_prev = 1'b0;
            m_beats      = '0;
        end else begin
            if (stall && m_stall_prev && (data_in != m_stall_dat)) m_ovf = 1'b1;
            m_stall_prev = stall;
            if (stall) m_stall_dat = data_in;
            if (do_pop) begin
                void'(q.pop_front());
                m_beats = m_beats + 32'd1;
            end
            if (do_push) q.push_back(data_in);
        end
        #1;
        chk("ready_sys", DW'(ready_sys), DW'(q.size() != DEPTH));
        chk("valid_out", DW'(valid_out), DW'(q.size() != 0));
        chk("count", DW'(count), DW'(q.size()));
        chk("overflow", DW'(overflow), DW'(m_ovf));
        if (q.size() > 0) chk("data_out", data_out, q[0]);
`ifdef AXIS_SLAVE_FIFO_STATS_EN
        chk("beat_cnt", DW'(beat_cnt), DW'(m_beats));
`endif
    endtask

    function automatic logic [DW-1:0] rand_beat();
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    initial begin
        reset = 1'b1; valid = 1'b0; ready_in = 1'b0; data_in = '0;
        m_ovf = 1'b0; m_stall_prev = 1'b0; m_beats = '0; m_stall_dat = '0;
        #100;
        step();
        reset = 1'b0;
        step();
        chk("idle_ready_sys", DW'(ready_sys), DW'(1));
        chk("idle_valid_out", DW'(valid_out), DW'(0));
        chk("idle_count", DW'(count), DW'(0));
        chk("idle_overflow", DW'(overflow), DW'(0));

        // Single beat, one-cycle latency, then drained
        ready_in = 1'b1; valid = 1'b1; data_in = DW'(64'hA5A5A5A5A5A5A5A5);
        step();
        chk("lat_valid", DW'(valid_out), DW'(1));
        chk("lat_data", data_out, DW'(64'hA5A5A5A5A5A5A5A5));
        valid = 1'b0;
        step();
        chk("lat_count0", DW'(count), DW'(0));

        // Fill with downstream stalled, then drain in order
        ready_in = 1'b0; valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            data_in = DW'(i);
            step();
        end
        chk("fill_count", DW'(count), DW'(4));
        chk("fill_ready", DW'(ready_sys), DW'(0));
        valid = 1'b0; ready_in = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("drain_order", data_out, DW'(i));
            step();
        end
        chk("drain_empty", DW'(valid_out), DW'(0));

        // Full FIFO, upstream changes data while stalled
        ready_in = 1'b0; valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            data_in = DW'(32'h50 + i);
            step();
        end
        data_in = DW'(64'h1234567890ABCDEF);
        step();
        step();
        chk("ovf_hold_clean", DW'(overflow), DW'(0));
        data_in = '0;
        step();
        chk("ovf_set", DW'(overflow), DW'(1));
        valid = 1'b0; ready_in = 1'b1;
        for (int i = 0; i < 3; i++) step();
        chk("ovf_sticky", DW'(overflow), DW'(1));
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("ovf_reset", DW'(overflow), DW'(0));

        // Streaming: count stays at one across pointer wrap
        valid = 1'b1; ready_in = 1'b1;
        for (int i = 0; i < 10; i++) begin
            data_in = DW'(32'h100 + i);
            step();
            chk("stream_count", DW'(count), DW'(1));
        end
        valid = 1'b0;
        step();

        // Reset mid-operation discards stored beats
        valid = 1'b1; ready_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            data_in = DW'(32'h200 + i);
            step();
        end
        chk("pre_reset_count", DW'(count), DW'(3));
        valid = 1'b0; reset = 1'b1;
        step();
        chk("rst_count", DW'(count), DW'(0));
        chk("rst_valid_out", DW'(valid_out), DW'(0));
        chk("rst_ready_sys", DW'(ready_sys), DW'(1));
`ifdef AXIS_SLAVE_FIFO_STATS_EN
        chk("rst_beat_cnt", DW'(beat_cnt), DW'(0));
`endif
        reset = 1'b0; ready_in = 1'b1;
        step();
        chk("post_rst_empty", DW'(valid_out), DW'(0));

        // Randomized, protocol-compliant traffic with shifting downstream pressure
        for (int c = 0; c < 600; c++) begin
            if (!(valid && !ready_sys)) begin
                valid   = ($urandom_range(0, 3) != 0);
                data_in = rand_beat();
            end
            if (c < 200)      ready_in = ($urandom_range(0, 3) == 0);
            else if (c < 400) ready_in = ($urandom_range(0, 1) == 0);
            else              ready_in = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/axis_slave_fifo.md
AXIS_SLAVE_FIFO -- requirements
Module: axis_slave_fifo

Interface
- REQ-001 The block SHALL have parameter DATA_WIDTH, default 512, giving the beat width in bits.
- REQ-002 The block SHALL have parameter DEPTH, default 4, giving the number of FIFO entries; legal values are powers of two, 2 to 16.
- REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
- REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
- REQ-005 The block SHALL have port valid, input, 1 bit: upstream AXI-stream master has a beat on data_in.
- REQ-006 The block SHALL have port data_in, input, DATA_WIDTH bits: upstream beat data.
- REQ-007 The block SHALL have port ready_sys, output, 1 bit: the block can accept a beat this cycle.
- REQ-008 The block SHALL have port valid_out, output, 1 bit: a beat is presented to the downstream consumer.
- REQ-009 The block SHALL have port data_out, output, DATA_WIDTH bits: the head-of-FIFO beat.
- REQ-010 The block SHALL have port ready_in, input, 1 bit: the downstream consumer accepts data_out.
- REQ-011 The block SHALL have port count, output, $clog2(DEPTH)+1 bits: current occupancy.
- REQ-012 The block SHALL have port overflow, output, 1 bit: sticky flag set when upstream changes data_in while valid is high and ready_sys is low (stall-protocol violation).

Function
- REQ-013 A push SHALL occur on a rising edge where valid && ready_sys; data_in is written at wr_ptr and wr_ptr increments modulo DEPTH.
- REQ-014 A pop SHALL occur on a rising edge where valid_out && ready_in; rd_ptr increments modulo DEPTH.
- REQ-015 ready_sys SHALL equal (count != DEPTH), combinationally from registered state only; it SHALL NOT depend on ready_in.
- REQ-016 valid_out SHALL equal (count != 0); data_out SHALL equal the entry at rd_ptr (show-ahead); there is no empty-to-output bypass.
- REQ-017 Latency SHALL be exactly 1 cycle: a beat pushed at edge N is on data_out with valid_out high after edge N, when the FIFO was empty.
- REQ-018 Simultaneous push and pop SHALL leave count unchanged and both pointers advanced.
- REQ-019 When full, push SHALL be impossible (ready_sys low); a same-cycle pop SHALL free one entry, visible as ready_sys high the following cycle.
- REQ-020 When empty, pop SHALL be impossible (valid_out low); data_out is don't-care.
- REQ-021 Beat order SHALL be preserved across pointer wrap-around.
- REQ-022 data_out SHALL remain stable while valid_out && !ready_in.
- REQ-023 The block SHALL register data_in on each stall cycle (valid && !ready_sys) and SHALL set overflow on a stall cycle whose data_in differs from the previous stall cycle's data_in; overflow clears only on reset.

Reset
- REQ-024 While reset is high at a rising edge, wr_ptr, rd_ptr and count SHALL go to 0, overflow to 0, and valid_out and count therefore read 0 and ready_sys reads 1.
- REQ-025 Reset mid-operation SHALL discard all stored beats; no beat pushed before reset shall appear after it.
- REQ-026 FIFO storage SHALL NOT require reset.

Configuration
- REQ-027 With macro AXIS_SLAVE_FIFO_STATS_EN defined, the block SHALL add output beat_cnt, 32 bits, incremented on every pop, wrapping at 2^32, reset to 0.
- REQ-028 Without AXIS_SLAVE_FIFO_STATS_EN, port beat_cnt and its counter SHALL be absent, and the remaining behaviour is identical.

Verification
- REQ-029 Reset 100 time units, then idle -> ready_sys=1, valid_out=0, count=0, overflow=0.
- REQ-030 Push 'hA5A5A5A5A5A5A5A5 with ready_in=1 -> valid_out=1 with data_out='hA5A5A5A5A5A5A5A5 one cycle later, then count returns to 0.
- REQ-031 ready_in=0, push 4 beats 1..4 -> count=4, ready_sys=0; then ready_in=1 -> data_out 1,2,3,4 in order.
- REQ-032 Full FIFO, hold valid=1 with data_in 'h1234567890ABCDEF, then change it to 'h0 while ready_sys=0 -> overflow=1 and stays 1.
- REQ-033 Continuous valid=1/ready_in=1 for 10 beats -> count constant at 1, all beats in order across pointer wrap.
- REQ-034 Reset asserted with count=3 -> next cycle count=0, valid_out=0; with STATS_EN, beat_cnt=0.
